// File: rtl/snn_input_loader.sv
// Byte-to-pixel unpacker for the SNN input RAM: writes eight 1-bit pixels per received byte,
// pulses start when the image is complete, then holds off new input until the core reports done.
module snn_input_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_rdy,
    input  logic [7:0]            i_rx_data,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_data,
    output logic                  o_start,
    input  logic                  i_done,
    output logic                  o_busy,
    output logic                  o_overrun
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cur;
    logic [2:0]            r_bit_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_pend;
    logic                  r_pend_v;
    logic                  r_overrun;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic                  r_hold_data;

    logic w_writing;
    logic w_last_bit;
    logic w_cur_bit;

    assign w_writing  = (r_state == S_WRITE);
    assign w_last_bit = (r_bit_idx == 3'd7);
    assign w_cur_bit  = r_cur[r_bit_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_bit_idx   <= '0;
            r_addr      <= '0;
            r_pend      <= '0;
            r_pend_v    <= 1'b0;
            r_overrun   <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_rdy) begin
                        r_cur     <= i_rx_data;
                        r_bit_idx <= '0;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_hold_addr <= r_addr;
                    r_hold_data <= w_cur_bit;
                    r_bit_idx   <= r_bit_idx + 3'd1;
                    if (w_last_bit && r_addr == LAST_ADDR) begin
                        // A byte arriving now is surplus; it is parked and discarded in START.
                        r_addr  <= '0;
                        r_state <= S_START;
                        if (i_rx_rdy) begin
                            if (r_pend_v) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_pend   <= i_rx_data;
                                r_pend_v <= 1'b1;
                            end
                        end
                    end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (w_last_bit) begin
                            if (r_pend_v) begin
                                r_cur    <= r_pend;
                                r_pend_v <= 1'b0;
                                if (i_rx_rdy) begin
                                    r_overrun <= 1'b1;
                                end
                            end else if (i_rx_rdy) begin
                                r_cur <= i_rx_data;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (i_rx_rdy) begin
                            if (r_pend_v) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_pend   <= i_rx_data;
                                r_pend_v <= 1'b1;
                            end
                        end
                    end
                end
                S_START: begin
                    r_addr   <= '0;
                    r_pend_v <= 1'b0;
                    if (r_pend_v || i_rx_rdy) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i_rx_rdy) begin
                        r_overrun <= 1'b1;
                    end
                    if (i_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Address and data show the live write, otherwise the last written values.
    assign o_ram_we   = w_writing;
    assign o_ram_addr = w_writing ? r_addr : r_hold_addr;
    assign o_ram_data = w_writing ? w_cur_bit : r_hold_data;
    assign o_start    = (r_state == S_START);
    assign o_busy     = (r_state != S_IDLE);
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed-plus-random bench for snn_input_loader: a RAM image model built from the received
// bytes is compared against the pixels the DUT writes, along with start/busy/overrun timing.
module tb_snn_input_loader;

    localparam int NP = 784;
    localparam int AW = 10;
    localparam int NB = NP / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_data;
    logic          start;
    logic          busy;
    logic          overrun;

    snn_input_loader #(.NUM_PIXELS(NP), .ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_rdy   (rx_rdy),
        .i_rx_data  (rx_data),
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_data (ram_data),
        .o_start    (start),
        .i_done     (done),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM as seen through the write port, plus write/start bookkeeping
    logic dut_ram [0:(1<<AW)-1];
    int   wr_count = 0;
    int   start_count = 0;
    int   start_cyc = -1;
    int   last_wr_cyc = -1;
    int   wr_cyc_q[$];
    int   wr_addr_q[$];

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            dut_ram[ram_addr] = ram_data;
            wr_count++;
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(int'(ram_addr));
            if (int'(ram_addr) == NP - 1) last_wr_cyc = cyc;
        end
        if (start === 1'b1) begin
            start_count++;
            start_cyc = cyc;
        end
    end

    logic [7:0] img [NB];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic exp_pix(input int p);
        logic [7:0] b;
        b = img[p / 8];
        return b[p % 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    task automatic send_image(input int gmin, input int gmax);
        for (int i = 0; i < NB; i++) begin
            send_byte(img[i]);
            if (i != NB - 1) idle(int'($urandom_range(gmax, gmin)) - 1);
        end
    endtask

    task automatic wait_start(input int budget);
        int k;
        k = 0;
        while (start !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("start_seen", start, 1);
    endtask

    task automatic check_image(input string tag, input int npix);
        int bad;
        bad = 0;
        for (int p = 0; p < npix; p++)
            if (dut_ram[p] !== exp_pix(p)) bad++;
        check(tag, bad, 0);
    endtask

    task automatic reset_and_check();
        rst = 1'b1;
        tick();
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done_busy_low", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a5;
        logic [7:0] b1, b2, b3;
        int sb, wb, qb, n0;

        rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; done = 1'b0;
        tick();
        reset_and_check();
        tick();

        // single byte 0xA5 from reset
        a5 = 8'hA5;
        sb = start_count;
        send_byte(a5);
        for (int i = 0; i < 8; i++) begin
            check("a5_we", ram_we, 1);
            check("a5_addr", ram_addr, i);
            check("a5_data", ram_data, a5[i]);
            tick();
        end
        check("a5_we_after", ram_we, 0);
        check("a5_busy_after", busy, 0);
        check("a5_addr_hold", ram_addr, 7);
        check("a5_data_hold", ram_data, 1);
        idle(5);
        check("a5_no_start", start_count - sb, 0);
        reset_and_check();
        tick();

        // full image of index bytes, spaced 20 cycles
        for (int i = 0; i < NB; i++) img[i] = 8'(i);
        sb = start_count; wb = wr_count;
        send_image(20, 20);
        wait_start(40);
        done = 1'b1;               // coincides with start: must be ignored
        tick();
        done = 1'b0;
        check("c_busy_after_early_done", busy, 1);
        check("c_start_timing", start_cyc, last_wr_cyc + 1);
        check("c_start_once", start_count - sb, 1);
        check("c_writes", wr_count - wb, NP);
        check("c_overrun", overrun, 0);
        check_image("c_image", NP);
        idle(2);
        check("c_busy_waiting", busy, 1);

        // bytes while waiting for done are dropped
        wb = wr_count;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom));
            idle(2);
        end
        check("wait_no_writes", wr_count - wb, 0);
        check("wait_overrun", overrun, 1);
        check("wait_busy", busy, 1);
        pulse_done();
        check("wait_start_once", start_count - sb, 1);

        // second image with random contents replaces the first
        for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
        sb = start_count; wb = wr_count; qb = wr_addr_q.size();
        send_image(8, 12);
        wait_start(40);
        tick();
        check("d_first_addr", wr_addr_q[qb], 0);
        check("d_start_once", start_count - sb, 1);
        check("d_start_timing", start_cyc, last_wr_cyc + 1);
        check("d_writes", wr_count - wb, NP);
        check_image("d_image", NP);
        idle(1);
        pulse_done();
        reset_and_check();
        tick();

        // back-to-back strobes, third one overruns
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        img[0] = b1; img[1] = b2;
        wb = wr_count; qb = wr_cyc_q.size(); n0 = cyc;
        rx_rdy = 1'b1;
        rx_data = b1; tick();
        rx_data = b2; tick();
        rx_data = b3; tick();
        rx_rdy = 1'b0;
        idle(30);
        check("b2b_writes", wr_count - wb, 16);
        check("b2b_first_cycle", wr_cyc_q[qb], n0 + 1);
        check("b2b_second_gap", wr_cyc_q[qb + 8] - wr_cyc_q[qb], 8);
        check("b2b_contiguous", wr_cyc_q[qb + 15] - wr_cyc_q[qb], 15);
        check("b2b_overrun", overrun, 1);
        check_image("b2b_image", 16);

        // partial image to 50 bytes, then reset mid-write
        for (int i = 2; i < 50; i++) begin
            send_byte(8'($urandom));
            if (i != 49) idle(int'($urandom_range(12, 8)) - 1);
        end
        reset_and_check();

        // fresh full image after the reset starts at address 0
        for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
        sb = start_count; wb = wr_count; qb = wr_addr_q.size();
        send_image(8, 12);
        wait_start(40);
        tick();
        check("f_first_addr", wr_addr_q[qb], 0);
        check("f_start_once", start_count - sb, 1);
        check("f_start_timing", start_cyc, last_wr_cyc + 1);
        check("f_writes", wr_count - wb, NP);
        check("f_overrun", overrun, 0);
        check_image("f_image", NP);
        idle(1);
        pulse_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
